mem_stage_pipe: RTL and testbench

//   Parametrised MEM pipeline stage: byte-addressed data RAM with word/half/byte loads and stores, sign/zero extension,

---
 rtl/mem_stage_pipe_if.sv | 36 +++
 rtl/mem_stage_pipe.sv | 138 +++++++++++++
 tb/tb_mem_stage_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pipe_if.sv
// EX/MEM -> MEM/WB bus for the memory stage; master is the upstream pipeline, slave is the stage.
interface mem_stage_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic [DATA_W-1:0]     ALUResult;
  logic [DATA_W-1:0]     WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [1:0]            MemSize;
  logic                  MemSigned;
  logic                  MemtoReg;
  logic                  RegWrite_In;
  logic [REG_ADDR_W-1:0] RegDestAddress;
  logic                  Stall;
  logic [DATA_W-1:0]     ALUResult_Out;
  logic [DATA_W-1:0]     ReadData;
  logic                  MemtoReg_Out;
  logic                  RegWrite_Out;
  logic [REG_ADDR_W-1:0] RegDestAddress_Out;
  logic                  MisalignErr;

  modport master (
    output ALUResult, WriteData, MemWrite, MemRead, MemSize, MemSigned,
           MemtoReg, RegWrite_In, RegDestAddress,
    input  Stall, ALUResult_Out, ReadData, MemtoReg_Out, RegWrite_Out,
           RegDestAddress_Out, MisalignErr
  );

  modport slave (
    input  ALUResult, WriteData, MemWrite, MemRead, MemSize, MemSigned,
           MemtoReg, RegWrite_In, RegDestAddress,
    output Stall, ALUResult_Out, ReadData, MemtoReg_Out, RegWrite_Out,
           RegDestAddress_Out, MisalignErr
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// MEM stage: byte-lane data RAM, sub-word load extension, load wait-state FSM and MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of silently aligning them.
module mem_stage_pipe #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_LATENCY = 0
) (
  input  logic Clk,
  input  logic Rst,
  mem_stage_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic [3:0][7:0]   ram [DEPTH];
  logic [AW-1:0]     wordIdx;
  logic [1:0]        lane;
  logic [3:0]        byteEn;
  logic [31:0]       storeWord, rdWord;
  logic [15:0]       halfV;
  logic [7:0]        byteV;
  logic [DATA_W-1:0] extV, loadVal;
  logic              misErr, isLoad, doStore, stall;

  assign wordIdx = bus.ALUResult[AW+1:2];

  // Low address bits are forced to the natural alignment of the access size.
  always_comb begin
    lane      = 2'b00;
    byteEn    = 4'hF;
    storeWord = bus.WriteData[31:0];
    unique case (bus.MemSize)
      2'b01: begin
        lane      = {bus.ALUResult[1], 1'b0};
        byteEn    = 4'b0011 << lane;
        storeWord = {2{bus.WriteData[15:0]}};
      end
      2'b10: begin
        lane      = bus.ALUResult[1:0];
        byteEn    = 4'b0001 << lane;
        storeWord = {4{bus.WriteData[7:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    unique case (bus.MemSize)
      2'b01:   misalign = bus.ALUResult[0];
      2'b10:   misalign = 1'b0;
      default: misalign = |bus.ALUResult[1:0];
    endcase
  end
  assign misErr = misalign & (bus.MemRead | bus.MemWrite);
`else
  assign misErr = 1'b0;
`endif

  assign doStore = bus.MemWrite & ~misErr & Rst;
  assign isLoad  = bus.MemRead & ~bus.MemWrite & ~misErr;

  always_ff @(posedge Clk) begin
    if (doStore)
      for (int i = 0; i < 4; i++)
        if (byteEn[i]) ram[wordIdx][i] <= storeWord[8*i +: 8];
  end

  assign rdWord = ram[wordIdx];
  assign halfV  = lane[1] ? rdWord[31:16] : rdWord[15:0];
  assign byteV  = rdWord[{lane, 3'b000} +: 8];

  always_comb begin
    unique case (bus.MemSize)
      2'b01:   extV = bus.MemSigned ? {{(DATA_W-16){halfV[15]}}, halfV} : {{(DATA_W-16){1'b0}}, halfV};
      2'b10:   extV = bus.MemSigned ? {{(DATA_W-8){byteV[7]}}, byteV} : {{(DATA_W-8){1'b0}}, byteV};
      default: extV = rdWord;
    endcase
  end

  assign loadVal = isLoad ? extV : '0;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stall     = 1'b0;
    unique case (state)
      IDLE: if (isLoad && MEM_LATENCY != 0) begin
        stall     = 1'b1;
        cntNext   = 4'(MEM_LATENCY - 1);
        stateNext = WAIT;
      end
      WAIT: if (cnt != 4'd0) begin
        stall   = 1'b1;
        cntNext = cnt - 4'd1;
      end else begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.Stall = stall;

  // A stall cycle pushes a bubble into write-back while upstream holds the load.
  always_ff @(posedge Clk) begin
    if (!Rst || stall) begin
      bus.ALUResult_Out      <= '0;
      bus.ReadData           <= '0;
      bus.MemtoReg_Out       <= 1'b0;
      bus.RegWrite_Out       <= 1'b0;
      bus.RegDestAddress_Out <= '0;
      bus.MisalignErr        <= 1'b0;
    end else begin
      bus.ALUResult_Out      <= bus.ALUResult;
      bus.ReadData           <= loadVal;
      bus.MemtoReg_Out       <= bus.MemtoReg;
      bus.RegWrite_Out       <= bus.RegWrite_In & ~misErr;
      bus.RegDestAddress_Out <= bus.RegDestAddress;
      bus.MisalignErr        <= misErr;
    end
  end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench: two stage instances (0 and 3 wait-states), directed loads/stores, monitors pop expectations.
module tb_mem_stage_pipe;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [1:0]  sz;
    logic        sgn;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
  } req_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        m2r;
    logic        mis;
  } exp_t;

  req_t req0, req3;
  exp_t q0[$], q3[$];
  int nChecks = 0;
  int nFail = 0;

  mem_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) if0();
  mem_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) if3();

  assign if0.ALUResult = req0.a;   assign if3.ALUResult = req3.a;
  assign if0.WriteData = req0.wd;  assign if3.WriteData = req3.wd;
  assign if0.MemWrite  = req0.we;  assign if3.MemWrite  = req3.we;
  assign if0.MemRead   = req0.re;  assign if3.MemRead   = req3.re;
  assign if0.MemSize   = req0.sz;  assign if3.MemSize   = req3.sz;
  assign if0.MemSigned = req0.sgn; assign if3.MemSigned = req3.sgn;
  assign if0.MemtoReg  = req0.m2r; assign if3.MemtoReg  = req3.m2r;
  assign if0.RegWrite_In    = req0.rw; assign if3.RegWrite_In    = req3.rw;
  assign if0.RegDestAddress = req0.rd; assign if3.RegDestAddress = req3.rd;

  mem_stage_pipe #(.DATA_W(32), .DEPTH(1024), .REG_ADDR_W(5), .MEM_LATENCY(0))
    dut0 (.Clk(Clk), .Rst(Rst), .bus(if0));
  mem_stage_pipe #(.DATA_W(32), .DEPTH(1024), .REG_ADDR_W(5), .MEM_LATENCY(3))
    dut3 (.Clk(Clk), .Rst(Rst), .bus(if3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input bit s, input logic [31:0] alu, input logic [31:0] data,
                     input logic [4:0] rd, input logic m2r, input logic mis);
    exp_t e;
    if ((s && q3.size() == 0) || (!s && q0.size() == 0)) begin
      nChecks++;
      nFail++;
      $display("FAIL unexpected output dut%0d: got alu=%h data=%h expected none", s ? 3 : 0, alu, data);
      return;
    end
    e = s ? q3.pop_front() : q0.pop_front();
    check(s ? "dut3 ALUResult_Out" : "dut0 ALUResult_Out", alu, e.alu);
    check(s ? "dut3 ReadData" : "dut0 ReadData", data, e.data);
    check(s ? "dut3 RegDestAddress_Out" : "dut0 RegDestAddress_Out", {27'b0, rd}, {27'b0, e.rd});
    check(s ? "dut3 MemtoReg_Out" : "dut0 MemtoReg_Out", {31'b0, m2r}, {31'b0, e.m2r});
    check(s ? "dut3 MisalignErr" : "dut0 MisalignErr", {31'b0, mis}, {31'b0, e.mis});
  endtask

  always @(negedge Clk)
    if (Rst === 1'b1 && (if0.RegWrite_Out === 1'b1 || if0.MisalignErr === 1'b1))
      mon(1'b0, if0.ALUResult_Out, if0.ReadData, if0.RegDestAddress_Out, if0.MemtoReg_Out, if0.MisalignErr);

  always @(negedge Clk)
    if (Rst === 1'b1 && (if3.RegWrite_Out === 1'b1 || if3.MisalignErr === 1'b1))
      mon(1'b1, if3.ALUResult_Out, if3.ReadData, if3.RegDestAddress_Out, if3.MemtoReg_Out, if3.MisalignErr);

  function automatic logic stallOf(input bit s);
    return s ? if3.Stall : if0.Stall;
  endfunction

  function automatic logic regWOf(input bit s);
    return s ? if3.RegWrite_Out : if0.RegWrite_Out;
  endfunction

  task automatic setReq(input bit s, input req_t r);
    if (s) req3 = r;
    else   req0 = r;
  endtask

  // Present one operation, hold it through any stall, then release it after the capture edge.
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic re, input logic [1:0] sz, input logic sgn,
                       input logic rw, input logic [4:0] rd, input logic [31:0] expData);
    req_t r;
    exp_t e;
    logic mis;
    int   n, expStall;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (re | we) && ((sz == 2'b01) ? a[0] : (sz == 2'b10) ? 1'b0 : (a[1:0] != 2'b00));
`endif
    r = '{a: a, wd: wd, we: we, re: re, sz: sz, sgn: sgn, m2r: re, rw: rw, rd: rd};
    if (rw || mis) begin
      e.alu  = a;
      e.data = mis ? 32'h0 : expData;
      e.rd   = rd;
      e.m2r  = re;
      e.mis  = mis;
      if (s) q3.push_back(e);
      else   q0.push_back(e);
    end
    expStall = (s && re && !we && !mis) ? 3 : 0;
    setReq(s, r);
    #1;
    n = 0;
    while (stallOf(s) === 1'b1 && n < 20) begin
      @(posedge Clk); #1;
      n++;
      check("bubble RegWrite_Out", {31'b0, regWOf(s)}, 32'h0);
    end
    check("stall cycles", n, expStall);
    @(posedge Clk); #1;
    setReq(s, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a load pending on both instances
    Rst  = 1'b0;
    req0 = '0; req0.re = 1'b1; req0.rw = 1'b1; req0.a = 32'h10;
    req3 = '0; req3.re = 1'b1; req3.rw = 1'b1; req3.a = 32'h10;
    @(posedge Clk); #1;
    Rst = 1'b1;
    req0 = '0;
    req3 = '0;
    #1;
    check("reset Stall", {31'b0, if3.Stall}, 32'h0);
    check("reset RegWrite_Out", {31'b0, if3.RegWrite_Out}, 32'h0);
    check("reset ReadData", if3.ReadData, 32'h0);
    check("reset ALUResult_Out", if3.ALUResult_Out, 32'h0);
    check("reset MisalignErr", {31'b0, if3.MisalignErr}, 32'h0);
    check("reset MemtoReg_Out", {31'b0, if0.MemtoReg_Out}, 32'h0);
    check("reset RegDestAddress_Out", {27'b0, if0.RegDestAddress_Out}, 32'h0);

    // Word store/load, zero wait-states
    issue(0, 32'h10, 32'hDEADBEEF, 1, 0, 2'b00, 0, 0, 5'd0, 32'h0);
    issue(0, 32'h10, 32'h0,        0, 1, 2'b00, 0, 1, 5'd1, 32'hDEADBEEF);

    // Sub-word loads and byte store
    issue(0, 32'h20, 32'h80817F80, 1, 0, 2'b00, 0, 0, 5'd0, 32'h0);
    issue(0, 32'h20, 32'h0,        0, 1, 2'b10, 1, 1, 5'd2, 32'hFFFFFF80);
    issue(0, 32'h23, 32'h0,        0, 1, 2'b10, 0, 1, 5'd3, 32'h00000080);
    issue(0, 32'h22, 32'h0,        0, 1, 2'b01, 1, 1, 5'd4, 32'hFFFF8081);
    issue(0, 32'h21, 32'h00000055, 1, 0, 2'b10, 0, 0, 5'd0, 32'h0);
    issue(0, 32'h20, 32'h0,        0, 1, 2'b00, 0, 1, 5'd5, 32'h80815580);

    // Non-memory pass-through and address wrap
    issue(0, 32'h12345678, 32'hFFFFFFFF, 0, 0, 2'b00, 0, 1, 5'd9, 32'h0);
    issue(0, 32'hFFFFF010, 32'h0,        0, 1, 2'b00, 0, 1, 5'd10, 32'hDEADBEEF);

    // Misaligned word store/load and misaligned half load
    issue(0, 32'h11, 32'hCAFEF00D, 1, 0, 2'b00, 0, 0, 5'd0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    issue(0, 32'h10, 32'h0, 0, 1, 2'b00, 0, 1, 5'd11, 32'hDEADBEEF);
`else
    issue(0, 32'h10, 32'h0, 0, 1, 2'b00, 0, 1, 5'd11, 32'hCAFEF00D);
`endif
    issue(0, 32'h11, 32'h0, 0, 1, 2'b00, 0, 1, 5'd12, 32'hCAFEF00D);
    issue(0, 32'h23, 32'h0, 0, 1, 2'b01, 0, 1, 5'd13, 32'h00008081);

    // Three wait-states
    issue(1, 32'h8,  32'h13579BDF, 1, 0, 2'b00, 0, 0, 5'd0,     32'h0);
    issue(1, 32'h8,  32'h0,        0, 1, 2'b00, 0, 1, 5'b10000, 32'h13579BDF);
    issue(1, 32'h40, 32'h0BADF00D, 1, 1, 2'b00, 0, 1, 5'd4,     32'h0);
    issue(1, 32'h42, 32'h0000A5A5, 1, 0, 2'b01, 0, 0, 5'd0,     32'h0);
    issue(1, 32'h40, 32'h0,        0, 1, 2'b00, 0, 1, 5'd6,     32'hA5A5F00D);
    issue(1, 32'h42, 32'h0,        0, 1, 2'b01, 1, 1, 5'd7,     32'hFFFFA5A5);
    issue(1, 32'h41, 32'h0,        0, 1, 2'b10, 1, 1, 5'd8,     32'hFFFFFFF0);

    // Reset in the second stall cycle drops the load
    req3 = '{a: 32'h8, wd: 32'h0, we: 1'b0, re: 1'b1, sz: 2'b00, sgn: 1'b0, m2r: 1'b1, rw: 1'b1, rd: 5'd7};
    #1;
    check("T5 stall cycle 1", {31'b0, if3.Stall}, 32'h1);
    @(posedge Clk); #1;
    check("T5 stall cycle 2", {31'b0, if3.Stall}, 32'h1);
    Rst = 1'b0;
    @(posedge Clk); #1;
    Rst  = 1'b1;
    req3 = '0;
    #1;
    check("T5 Stall after reset", {31'b0, if3.Stall}, 32'h0);
    check("T5 RegWrite_Out", {31'b0, if3.RegWrite_Out}, 32'h0);
    check("T5 ReadData", if3.ReadData, 32'h0);
    check("T5 ALUResult_Out", if3.ALUResult_Out, 32'h0);
    issue(1, 32'h8, 32'h0, 0, 1, 2'b00, 0, 1, 5'd8, 32'h13579BDF);

    repeat (3) @(posedge Clk);
    #1;
    check("dut0 scoreboard drained", q0.size(), 32'h0);
    check("dut3 scoreboard drained", q3.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
